// File: rtl/pc_predict_unit.sv
// Fetch-stage next-PC generator: registered fetch PC, direct-mapped BTB with
// 2-bit counters, EX-stage resolution and trap/mispredict redirect.
module pc_predict_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_stall,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic            i_ex_valid,
  input  logic [1:0]      i_ex_kind,
  input  logic            i_ex_cond,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_ex_rs1,
  input  logic [XLEN-1:0] i_ex_imm,
  input  logic            i_ex_pred_taken,
  input  logic [XLEN-1:0] i_ex_pred_target,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  output logic            o_redirect
);

  localparam int unsigned IDX   = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  localparam logic [1:0] KIND_NONE   = 2'b00;
  localparam logic [1:0] KIND_BRANCH = 2'b01;
  localparam logic [1:0] KIND_JAL    = 2'b10;
  localparam logic [1:0] KIND_JALR   = 2'b11;

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  // BTB storage
  logic             r_valid   [BTB_DEPTH];
  logic [1:0]       r_ctr     [BTB_DEPTH];
  logic [TAG_W-1:0] r_tag     [BTB_DEPTH];
  logic [XLEN-1:0]  r_target  [BTB_DEPTH];
  logic             r_is_jump [BTB_DEPTH];

  logic [XLEN-1:0]  r_pc;

  // ---------------------------------------------------------------------------
  // Lookup on the current fetch PC
  // ---------------------------------------------------------------------------
  logic [IDX-1:0]   w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_pred_taken;
  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_pred_target;

  assign w_idx         = r_pc[IDX+1:2];
  assign w_tag         = r_pc[XLEN-1:IDX+2];
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_pred_taken  = w_hit && (r_is_jump[w_idx] || r_ctr[w_idx][1]);
  assign w_pc_plus4    = r_pc + PC_STEP;
  assign w_pred_target = w_pred_taken ? r_target[w_idx] : w_pc_plus4;

  // ---------------------------------------------------------------------------
  // Resolution of the instruction in EX
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  w_ex_target;
  logic [XLEN-1:0]  w_ex_actual;
  logic             w_ex_taken;
  logic             w_mispredict;
  logic [IDX-1:0]   w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;

  assign w_ex_target = (i_ex_kind == KIND_JALR) ? ((i_ex_rs1 + i_ex_imm) & JALR_MASK)
                                                : (i_ex_pc + i_ex_imm);
  assign w_ex_taken  = (i_ex_kind == KIND_JAL) || (i_ex_kind == KIND_JALR) ||
                       ((i_ex_kind == KIND_BRANCH) && i_ex_cond);
  assign w_ex_actual = w_ex_taken ? w_ex_target : (i_ex_pc + PC_STEP);

  // Kind 00 predicted taken is an alias hit and still counts as a mispredict.
  assign w_mispredict = i_ex_valid &&
                        ((w_ex_taken != i_ex_pred_taken) ||
                         (w_ex_taken && (w_ex_target != i_ex_pred_target)));

  assign w_ex_idx = i_ex_pc[IDX+1:2];
  assign w_ex_tag = i_ex_pc[XLEN-1:IDX+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  // ---------------------------------------------------------------------------
  // Next-PC selection: trap > mispredict > stall > prediction
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] w_next_pc;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next_pc = w_pred_target;
    if (i_trap_valid)      w_next_pc = i_trap_vec;
    else if (w_mispredict) w_next_pc = w_ex_actual;
    else if (i_stall)      w_next_pc = r_pc;
  end

  // ---------------------------------------------------------------------------
  // BTB update decode; a trap squashes the EX instruction's training
  // ---------------------------------------------------------------------------
  logic       w_upd;
  logic       w_valid_we;
  logic       w_valid_d;
  logic       w_ctr_we;
  logic [1:0] w_ctr_d;
  logic       w_target_we;
  logic       w_meta_we;
  logic       w_is_jump_d;
  logic [1:0] w_ctr_cur;

  assign w_upd     = i_ex_valid && !i_trap_valid;
  assign w_ctr_cur = r_ctr[w_ex_idx];

  always_comb begin
    w_valid_we  = 1'b0;
    w_valid_d   = 1'b0;
    w_ctr_we    = 1'b0;
    w_ctr_d     = w_ctr_cur;
    w_target_we = 1'b0;
    w_meta_we   = 1'b0;
    w_is_jump_d = 1'b0;
    if (w_upd) begin
      case (i_ex_kind)
        KIND_NONE: begin
          if (w_ex_hit) begin
            w_valid_we = 1'b1;
            w_valid_d  = 1'b0;
          end
        end
        KIND_JAL, KIND_JALR: begin
          w_valid_we  = 1'b1;
          w_valid_d   = 1'b1;
          w_ctr_we    = 1'b1;
          w_ctr_d     = 2'b11;
          w_target_we = 1'b1;
          w_meta_we   = 1'b1;
          w_is_jump_d = 1'b1;
        end
        default: begin // KIND_BRANCH
          if (w_ex_hit) begin
            w_ctr_we    = 1'b1;
            w_target_we = w_ex_taken;
            if (w_ex_taken) w_ctr_d = (w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'b01;
            else            w_ctr_d = (w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'b01;
          end else if (w_ex_taken) begin
            w_valid_we  = 1'b1;
            w_valid_d   = 1'b1;
            w_ctr_we    = 1'b1;
            w_ctr_d     = 2'b10;
            w_target_we = 1'b1;
            w_meta_we   = 1'b1;
            w_is_jump_d = 1'b0;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; this also gives read-before-write on the BTB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b00;
      end
    end else begin
      r_pc <= w_next_pc;
      if (w_valid_we) r_valid[w_ex_idx] <= w_valid_d;
      if (w_ctr_we)   r_ctr[w_ex_idx]   <= w_ctr_d;
    end
  end

  // NOTE: tag/target/is_jump are payload qualified by r_valid, so they are left
  // out of reset and can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_target_we) r_target[w_ex_idx] <= w_ex_target;
    if (w_meta_we) begin
      r_tag[w_ex_idx]     <= w_ex_tag;
      r_is_jump[w_ex_idx] <= w_is_jump_d;
    end
  end

  assign o_pc          = r_pc;
  assign o_pred_taken  = w_pred_taken;
  assign o_pred_target = w_pred_target;
  assign o_redirect    = i_trap_valid || w_mispredict;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed self-checking bench for pc_predict_unit (XLEN=32, BTB_DEPTH=16).
module tb_pc_predict_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        trap_valid;
  logic [31:0] trap_vec;
  logic        ex_valid;
  logic [1:0]  ex_kind;
  logic        ex_cond;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1;
  logic [31:0] ex_imm;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        redirect;

  int n_checks = 0;
  int n_fail   = 0;

  pc_predict_unit #(.XLEN(32), .RESET_PC(32'h0), .BTB_DEPTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_stall          (stall),
    .i_trap_valid     (trap_valid),
    .i_trap_vec       (trap_vec),
    .i_ex_valid       (ex_valid),
    .i_ex_kind        (ex_kind),
    .i_ex_cond        (ex_cond),
    .i_ex_pc          (ex_pc),
    .i_ex_rs1         (ex_rs1),
    .i_ex_imm         (ex_imm),
    .i_ex_pred_taken  (ex_pred_taken),
    .i_ex_pred_target (ex_pred_target),
    .o_pc             (pc),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target),
    .o_redirect       (redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid       = 1'b0;
    ex_kind        = 2'b00;
    ex_cond        = 1'b0;
    ex_pc          = '0;
    ex_rs1         = '0;
    ex_imm         = '0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = '0;
  endtask

  task automatic drive_ex(input logic [1:0] kind, input logic cond, input logic [31:0] epc,
                          input logic [31:0] rs1, input logic [31:0] imm,
                          input logic ptaken, input logic [31:0] ptarget);
    ex_valid       = 1'b1;
    ex_kind        = kind;
    ex_cond        = cond;
    ex_pc          = epc;
    ex_rs1         = rs1;
    ex_imm         = imm;
    ex_pred_taken  = ptaken;
    ex_pred_target = ptarget;
  endtask

  task automatic trap_to(input logic [31:0] vec);
    trap_valid = 1'b1;
    trap_vec   = vec;
    #1;
    check("trap_redirect", {31'b0, redirect}, 32'd1);
    tick();
    trap_valid = 1'b0;
    check("trap_pc", pc, vec);
  endtask

  initial begin
    rst        = 1'b1;
    stall      = 1'b0;
    trap_valid = 1'b0;
    trap_vec   = '0;
    idle();
    #2;
    check("rst_pc", pc, 32'h0);
    check("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
    check("rst_pred_target", pred_target, 32'h4);
    check("rst_redirect", {31'b0, redirect}, 32'd0);
    #5 rst = 1'b0;

    // Sequential fetch
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq_pc", pc, 32'(4 * i));
      check("seq_pred_taken", {31'b0, pred_taken}, 32'd0);
    end

    // Branch learn: taken branch at 0x40, imm -8, predicted not taken
    drive_ex(2'b01, 1'b1, 32'h40, 32'h0, 32'hFFFF_FFF8, 1'b0, 32'h0);
    #1;
    check("learn_redirect", {31'b0, redirect}, 32'd1);
    tick();
    idle();
    check("learn_pc", pc, 32'h38);
    check("learn_miss_pred", {31'b0, pred_taken}, 32'd0);
    check("learn_miss_target", pred_target, 32'h3C);
    tick();
    tick();
    check("learn_hit_pc", pc, 32'h40);
    check("learn_hit_pred", {31'b0, pred_taken}, 32'd1);
    check("learn_hit_target", pred_target, 32'h38);
    tick();
    check("learn_follow_pc", pc, 32'h38);

    // Counter hysteresis: 10 -> 01 without redirect, then mispredict 01 -> 00
    drive_ex(2'b01, 1'b0, 32'h40, 32'h0, 32'hFFFF_FFF8, 1'b0, 32'h0);
    #1;
    check("hyst1_redirect", {31'b0, redirect}, 32'd0);
    tick();
    idle();
    check("hyst1_pc", pc, 32'h3C);
    drive_ex(2'b01, 1'b0, 32'h40, 32'h0, 32'hFFFF_FFF8, 1'b1, 32'h38);
    #1;
    check("hyst2_redirect", {31'b0, redirect}, 32'd1);
    tick();
    idle();
    check("hyst2_pc", pc, 32'h44);
    trap_to(32'h40);
    check("hyst_lookup_pred", {31'b0, pred_taken}, 32'd0);
    check("hyst_lookup_target", pred_target, 32'h44);

    // Jalr: bit 0 of the sum is cleared
    drive_ex(2'b11, 1'b0, 32'h200, 32'h1003, 32'h4, 1'b0, 32'h0);
    #1;
    check("jalr_redirect", {31'b0, redirect}, 32'd1);
    tick();
    idle();
    check("jalr_pc", pc, 32'h1006);
    drive_ex(2'b11, 1'b0, 32'h200, 32'h1003, 32'h4, 1'b1, 32'h2000);
    #1;
    check("jalr_stale_redirect", {31'b0, redirect}, 32'd1);
    tick();
    idle();
    check("jalr_stale_pc", pc, 32'h1006);

    // Priority: trap over mispredict over stall, and trap blocks BTB training
    stall      = 1'b1;
    trap_valid = 1'b1;
    trap_vec   = 32'h80;
    drive_ex(2'b01, 1'b1, 32'h80, 32'h0, 32'h10, 1'b0, 32'h0);
    #1;
    check("prio_trap_redirect", {31'b0, redirect}, 32'd1);
    tick();
    idle();
    trap_valid = 1'b0;
    check("prio_trap_pc", pc, 32'h80);
    check("prio_trap_no_alloc", {31'b0, pred_taken}, 32'd0);
    drive_ex(2'b01, 1'b1, 32'h100, 32'h0, 32'h20, 1'b0, 32'h0);
    #1;
    check("prio_mp_redirect", {31'b0, redirect}, 32'd1);
    tick();
    idle();
    check("prio_mp_pc", pc, 32'h120);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_pc", pc, 32'h120);
    end
    stall = 1'b0;

    // Wrap at the top of the address space
    trap_to(32'hFFFF_FFFC);
    check("wrap_pred", {31'b0, pred_taken}, 32'd0);
    check("wrap_target", pred_target, 32'h0);
    tick();
    check("wrap_pc", pc, 32'h0);

    // Alias: install jal at 0x80, then a kind-00 at 0x80 predicted taken
    drive_ex(2'b10, 1'b0, 32'h80, 32'h0, 32'h40, 1'b1, 32'hC0);
    #1;
    check("jal_correct_redirect", {31'b0, redirect}, 32'd0);
    tick();
    idle();
    check("jal_correct_pc", pc, 32'h4);
    trap_to(32'h80);
    check("alias_hit_pred", {31'b0, pred_taken}, 32'd1);
    check("alias_hit_target", pred_target, 32'hC0);
    drive_ex(2'b00, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, 32'hC0);
    #1;
    check("alias_redirect", {31'b0, redirect}, 32'd1);
    check("alias_same_cycle_pred", {31'b0, pred_taken}, 32'd1);
    tick();
    idle();
    check("alias_pc", pc, 32'h84);
    trap_to(32'h80);
    check("alias_invalid_pred", {31'b0, pred_taken}, 32'd0);
    check("alias_invalid_target", pred_target, 32'h84);

    // Async reset during a stall
    stall = 1'b1;
    tick();
    check("pre_rst_hold_pc", pc, 32'h80);
    rst = 1'b1;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_pred", {31'b0, pred_taken}, 32'd0);
    stall = 1'b0;
    rst   = 1'b0;
    tick();
    check("post_rst_pc", pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Parametrised next-PC generator for the fetch stage, successor to the fixed 32-bit PC register. Holds the fetch PC and predicts the next fetch address with a direct-mapped branch target buffer (BTB) using 2-bit counters. It resolves jal/jalr/branch outcomes reported from EX, and redirects on mispredict or trap. Stall and flush-priority handling are built in.

## Interface
- XLEN, 32: PC/data width; ≥ 8.
- RESET_PC, 0: PC value after reset; XLEN bits, 4-byte aligned.
- BTB_DEPTH, 16: BTB entries; power of two, ≥ 2; IDX = log2(BTB_DEPTH).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold PC; ignored when redirecting.
- trap_valid  in  1  take trap this cycle.
- trap_vec  in  XLEN  trap target.
- ex_valid  in  1  EX holds a valid instruction.
- ex_kind  in  2  00 none, 01 branch, 10 jal, 11 jalr.
- ex_cond  in  1  branch condition true (beq/bne/etc. already evaluated).
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_rs1  in  XLEN  rs1 read data.
- ex_imm  in  XLEN  sign-extended immediate.
- ex_pred_taken  in  1  prediction carried down with the instruction.
- ex_pred_target  in  XLEN  predicted target carried down.
- pc  out  XLEN  current fetch PC (registered).
- pred_taken  out  1  BTB predicts taken for pc.
- pred_target  out  XLEN  predicted target for pc.
- redirect  out  1  mispredict or trap this cycle; upstream flushes IF/ID.

## Operation
- BTB entry fields: valid, tag = pc[XLEN-1:IDX+2], target, is_jump, ctr[1:0]. Index = pc[IDX+1:2].
- Lookup on pc: hit = valid & tag match. pred_taken = hit & (is_jump | ctr[1]). pred_target = entry target when pred_taken; otherwise pc+4.
- Resolution, all arithmetic modulo 2^XLEN in two's complement; no special negative-immediate paths:
  - target = (ex_rs1+ex_imm) & ~1 for jalr; ex_pc+ex_imm otherwise.
  - taken = jal | jalr | (branch & ex_cond).
  - actual = taken ? target : ex_pc+4.
- mispredict = ex_valid & (taken != ex_pred_taken | (taken & target != ex_pred_target)). This includes kind 00 predicted taken (aliasing).
- Next-PC priority, highest first:
  - trap_valid → trap_vec.
  - mispredict → actual.
  - stall → hold.
  - pred_taken → pred_target.
  - otherwise pc+4.
- redirect = trap_valid | mispredict, combinational.
- BTB update on the edge when ex_valid & !trap_valid, independent of stall:
  - Kind 00 with a hit on ex_pc: clear valid.
  - Jal/jalr: write valid, tag, target, is_jump=1, ctr=11.
  - Branch, hit: ctr saturating +1 if taken, −1 if not; target overwritten when taken.
  - Branch, miss, taken: allocate with ctr=10, is_jump=0.
  - Branch, miss, not taken: no write.

## Timing
- Reset (async): pc=RESET_PC, all valid=0, all ctr=00. Hence pred_taken=0, pred_target=RESET_PC+4, redirect follows inputs.
- pc updates one clk after the decision. Redirect target appears on pc the cycle after redirect=1.
- Lookup and redirect are combinational, same cycle as inputs.
- Update and lookup to the same index in one cycle: the lookup sees pre-update contents. The new entry is visible the next cycle.
- Counter saturates at 00 and 11; no wrap.
- pc+4 at 2^XLEN−4 wraps to 0. Targets wrap likewise.
- Reset asserted mid-stall or mid-redirect: the async reset wins immediately. The first post-reset edge fetches RESET_PC+4.

## Test plan
- Reset/sequential: rst pulse, no EX activity, 4 cycles → pc 0, 4, 8, 12, 16; pred_taken=0.
- Branch learn (XLEN=32, BTB_DEPTH=16):
  - Taken branch at ex_pc=0x40, imm=−8, pred_taken=0 → redirect=1, next pc=0x38, entry allocated ctr=10.
  - When pc=0x40 later → pred_taken=1, pred_target=0x38.
- Counter hysteresis: same branch resolved not-taken twice with correct preds → ctr 10→01, second time mispredict. pc=0x44 after redirect; next lookup pred_taken=0.
- Jalr: ex_rs1=0x1003, imm=4, pred_taken=0 → target 0x1006 (bit0 cleared), redirect=1. A jalr with a stale pred_target of 0x2000 also → redirect to 0x1006.
- Priority: trap_valid=1 with mispredict and stall in the same cycle → pc=trap_vec, BTB unchanged. Stall plus mispredict → pc=actual. Stall alone → pc held for 3 cycles.
- Wrap/alias: pc=0xFFFFFFFC, no hit → next pc=0.
  - Kind-00 instruction with ex_pred_taken=1 at 0x80 → redirect to 0x84, entry invalidated.
